hr_scroll_pacer: RTL and testbench

HR_SCROLL_PACER -- requirements
Module: hr_scroll_pacer

---
 rtl/hr_pkg.sv | 32 +++
 rtl/hr_debounce.sv | 57 +++++
 rtl/hr_scroll_pacer.sv | 86 ++++++++
 tb/tb_hr_scroll_pacer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hr_pkg.sv
// Shared types and decode for the heart-rate scroll pacer.
// Sensor codes map onto scroll speed steps; four of the eight codes are invalid.
package hr_pkg;

    typedef logic [1:0] speed_t;
    typedef logic [2:0] hr_code_t;

    localparam hr_code_t CODE_FAST = 3'b000;
    localparam hr_code_t CODE_SLOW = 3'b001;
    localparam hr_code_t CODE_MED  = 3'b011;
    localparam hr_code_t CODE_REST = 3'b111;

    typedef struct packed {
        logic   valid;
        speed_t speed;
    } hr_decode_t;

    function automatic hr_decode_t decode_code(input hr_code_t code);
        hr_decode_t d;
        d.valid = 1'b1;
        d.speed = 2'd0;
        case (code)
            CODE_FAST: d.speed = 2'd3;
            CODE_SLOW: d.speed = 2'd1;
            CODE_MED:  d.speed = 2'd2;
            CODE_REST: d.speed = 2'd1;
            default:   d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hr_debounce.sv
// Two-flop synchronizer plus candidate/counter debounce for the heart-rate code.
// accept pulses combinationally on the edge where the counter reaches DEB_CYCLES-1.
module hr_debounce
    import hr_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1000
) (
    input  logic     clk,
    input  logic     clr,
    input  hr_code_t din,
    output hr_code_t code,
    output logic     accept
);

    localparam logic [15:0] CNT_LAST = 16'(DEB_CYCLES - 1);

    hr_code_t    sync1_q, sync1_d;
    hr_code_t    sync2_q, sync2_d;
    hr_code_t    cand_q,  cand_d;
    logic [15:0] cnt_q,   cnt_d;
    logic        accept_d;

    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        accept_d = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d   = sync2_q;
            cnt_d    = 16'd0;
            accept_d = (CNT_LAST == 16'd0);
        end else if (cnt_q != CNT_LAST) begin
            // Saturating count: a held code is accepted once, not every wrap.
            cnt_d    = cnt_q + 16'd1;
            accept_d = ((cnt_q + 16'd1) == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign code   = sync2_q;
    assign accept = accept_d & ~clr;

endmodule

// File: rtl/hr_scroll_pacer.sv
// Heart-rate driven scroll pacer: debounced code -> speed -> phase accumulator -> tick.
// HR_FAULT_LATCH_EN makes hr_fault sticky until clr; otherwise it tracks the last accepted code.
module hr_scroll_pacer
    import hr_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1000,
    parameter int unsigned ACC_W      = 18
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             heartrate1,
    input  logic             heartrate2,
    input  logic             heartrate3,
    input  logic             run,
    output logic [1:0]       speed,
    output logic             hr_valid,
    output logic             hr_fault,
    output logic             scroll_tick,
    output logic [ACC_W-1:0] phase
);

    hr_code_t   acc_code;
    logic       acc_stb;
    hr_decode_t dec;

    speed_t     speed_q,    speed_d;
    logic       hr_valid_q, hr_valid_d;
    logic       hr_fault_q, hr_fault_d;
    logic       tick_q,     tick_d;
    logic [ACC_W-1:0] phase_q, phase_d;

    hr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
        .clk    (clk),
        .clr    (clr),
        .din    ({heartrate1, heartrate2, heartrate3}),
        .code   (acc_code),
        .accept (acc_stb)
    );

    assign dec = decode_code(acc_code);

    always_comb begin
        speed_d    = speed_q;
        hr_valid_d = hr_valid_q;
        hr_fault_d = hr_fault_q;
        // Accumulate with the speed in force before this edge's acceptance.
        phase_d    = run ? phase_q + ACC_W'(speed_q) : phase_q;
        tick_d     = run & ~phase_q[ACC_W-1] & phase_d[ACC_W-1];
        if (acc_stb) begin
            if (dec.valid) begin
                speed_d    = dec.speed;
                hr_valid_d = 1'b1;
`ifdef HR_FAULT_LATCH_EN
                hr_fault_d = hr_fault_q;
`else
                hr_fault_d = 1'b0;
`endif
            end else begin
                hr_fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            speed_q    <= '0;
            hr_valid_q <= 1'b0;
            hr_fault_q <= 1'b0;
            tick_q     <= 1'b0;
            phase_q    <= '0;
        end else begin
            speed_q    <= speed_d;
            hr_valid_q <= hr_valid_d;
            hr_fault_q <= hr_fault_d;
            tick_q     <= tick_d;
            phase_q    <= phase_d;
        end
    end

    assign speed       = speed_q;
    assign hr_valid    = hr_valid_q;
    assign hr_fault    = hr_fault_q;
    assign scroll_tick = tick_q;
    assign phase       = phase_q;

endmodule

// File: tb/tb_hr_scroll_pacer.sv
// Bench for hr_scroll_pacer (DEB_CYCLES=4, ACC_W=4): directed scenarios plus random
// code/run/clr traffic against a run-length / modular-arithmetic reference model.
module tb_hr_scroll_pacer;

    localparam int DEB  = 4;
    localparam int AW   = 4;
    localparam int MODV = 1 << AW;
    localparam int HALF = 1 << (AW - 1);

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          heartrate1 = 1'b0, heartrate2 = 1'b0, heartrate3 = 1'b1;
    logic          run = 1'b1;
    logic [1:0]    speed;
    logic          hr_valid, hr_fault, scroll_tick;
    logic [AW-1:0] phase;

    always #5 clk = ~clk;

    hr_scroll_pacer #(.DEB_CYCLES(DEB), .ACC_W(AW)) dut (
        .clk         (clk),
        .clr         (clr),
        .heartrate1  (heartrate1),
        .heartrate2  (heartrate2),
        .heartrate3  (heartrate3),
        .run         (run),
        .speed       (speed),
        .hr_valid    (hr_valid),
        .hr_fault    (hr_fault),
        .scroll_tick (scroll_tick),
        .phase       (phase)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int ticks_seen = 0;

    // Reference model: 2-edge input delay, run length of the held code, spec decode table.
    int m_d1 = 0, m_d2 = 0, m_cand = 0, m_run = 1;
    int m_speed = 0, m_valid = 0, m_fault = 0, m_phase = 0, m_tick = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    endtask

    task automatic set_code(input int c);
        logic [2:0] v;
        v = 3'(c);
        {heartrate1, heartrate2, heartrate3} = v;
    endtask

    task automatic model_edge(input int raw, input bit c_clr, input bit c_run);
        int v, np, spd;
        bit acc, ok;
        if (c_clr) begin
            m_d1 = 0; m_d2 = 0; m_cand = 0; m_run = 1;
            m_speed = 0; m_valid = 0; m_fault = 0; m_phase = 0; m_tick = 0;
            return;
        end
        v = m_d2;
        m_d2 = m_d1;
        m_d1 = raw;
        acc = 1'b0;
        if (v != m_cand) begin
            m_cand = v;
            m_run  = 1;
            acc    = (DEB == 1);
        end else if (m_run < DEB) begin
            m_run++;
            acc = (m_run == DEB);
        end
        np     = c_run ? (m_phase + m_speed) % MODV : m_phase;
        m_tick = (c_run && m_phase < HALF && np >= HALF) ? 1 : 0;
        m_phase = np;
        if (acc) begin
            ok  = 1'b1;
            spd = 0;
            case (m_cand)
                0: spd = 3;
                1: spd = 1;
                3: spd = 2;
                7: spd = 1;
                default: ok = 1'b0;
            endcase
            if (ok) begin
                m_speed = spd;
                m_valid = 1;
`ifndef HR_FAULT_LATCH_EN
                m_fault = 0;
`endif
            end else begin
                m_fault = 1;
            end
        end
    endtask

    task automatic step();
        int raw;
        @(posedge clk);
        raw = int'({heartrate1, heartrate2, heartrate3});
        model_edge(raw, clr, run);
        #1;
        chk("speed",    int'(speed),       m_speed);
        chk("hr_valid", int'(hr_valid),    m_valid);
        chk("hr_fault", int'(hr_fault),    m_fault);
        chk("tick",     int'(scroll_tick), m_tick);
        chk("phase",    int'(phase),       m_phase);
        if (scroll_tick) ticks_seen++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int t0, ph0, k;
        bit reached;

        // Reset with code 001 already on the lines.
        steps(3);
        chk("rst_speed", int'(speed), 0);
        chk("rst_valid", int'(hr_valid), 0);
        chk("rst_tick",  int'(scroll_tick), 0);
        clr = 1'b0;

        // Accepted exactly on edge 6 after release.
        steps(5);
        chk("valid_edge5", int'(hr_valid), 0);
        step();
        chk("valid_edge6", int'(hr_valid), 1);
        chk("speed_001",   int'(speed), 1);
        t0 = ticks_seen; steps(64);
        chk("ticks_spd1_64", ticks_seen - t0, 4);

        set_code(3); steps(10);
        chk("speed_011", int'(speed), 2);
        t0 = ticks_seen; steps(32);
        chk("ticks_spd2_32", ticks_seen - t0, 4);
        set_code(0); steps(10);
        chk("speed_000", int'(speed), 3);
        t0 = ticks_seen; steps(16);
        chk("ticks_spd3_16", ticks_seen - t0, 3);

        // Short glitch must not be accepted.
        set_code(1); steps(10);
        set_code(3); steps(3);
        set_code(1); steps(12);
        chk("glitch_speed", int'(speed), 1);

        set_code(5); steps(10);
        chk("fault_101", int'(hr_fault), 1);
        chk("speed_hold_101", int'(speed), 1);
        set_code(1); steps(10);
`ifdef HR_FAULT_LATCH_EN
        chk("fault_after_001", int'(hr_fault), 1);
`else
        chk("fault_after_001", int'(hr_fault), 0);
`endif

        // Pause freezes phase and ticks.
        run = 1'b0;
        ph0 = int'(phase);
        t0  = ticks_seen;
        steps(20);
        chk("pause_phase", int'(phase), ph0);
        chk("pause_ticks", ticks_seen - t0, 0);
        run = 1'b1;
        step();
        chk("resume_phase", int'(phase), (ph0 + 1) % MODV);

        // clr while phase=7 with an acceptance in flight.
        reached = 1'b0;
        for (k = 0; k < 40 && !reached; k++) begin
            step();
            if (m_phase == 4) reached = 1'b1;
        end
        chk("reach_phase4", int'(reached), 1);
        set_code(3); steps(3);
        chk("phase_pre_clr", int'(phase), 7);
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_speed", int'(speed), 0);
        chk("clr_phase", int'(phase), 0);
        chk("clr_tick",  int'(scroll_tick), 0);
        chk("clr_valid", int'(hr_valid), 0);
        steps(3);
        chk("discarded", int'(speed), 0);
        steps(10);
        chk("reaccept_011", int'(speed), 2);

        // Random traffic.
        for (int s = 0; s < 250; s++) begin
            set_code(int'($urandom_range(0, 7)));
            run = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) begin
                clr = 1'b1; step(); clr = 1'b0;
            end
            steps(int'($urandom_range(1, 10)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
